// File: rtl/hwag_angle_if.sv
// Bus between the tooth/period capture logic and the angle counter stage.
// master drives the tooth data and the configuration; slave returns the angle outputs.
interface hwag_angle_if #(
   parameter int ACNT_W = 24,
   parameter int SCNT_W = 22,
   parameter int TCKC_W = 19
);
   logic              ena;
   logic              tooth_edge;
   logic [ACNT_W-1:0] tooth_angle;
   logic [SCNT_W-1:0] scnt_top;
   logic [TCKC_W-1:0] tckc_top;
   logic [ACNT_W-1:0] acnt_top;
   logic [ACNT_W-1:0] acnt;
   logic              acnt_tick;
   logic              acnt_valid;
   logic              stall;
   logic              early_if;
   logic              overrun_if;

   modport master (
      output ena, tooth_edge, tooth_angle, scnt_top, tckc_top, acnt_top,
      input  acnt, acnt_tick, acnt_valid, stall, early_if, overrun_if
   );

   modport slave (
      input  ena, tooth_edge, tooth_angle, scnt_top, tckc_top, acnt_top,
      output acnt, acnt_tick, acnt_valid, stall, early_if, overrun_if
   );
endinterface

// File: rtl/hwag_angle_counter.sv
// Interpolates crank angle between VR tooth edges: divides the tooth period into ticks.
// Optional macro HWAG_ACNT_CATCHUP_EN replays missed ticks after an early edge.
module hwag_angle_counter #(
   parameter int ACNT_W = 24,
   parameter int SCNT_W = 22,
   parameter int TCKC_W = 19
) (
   input  logic           clk,
   input  logic           rst,
   hwag_angle_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      RUN,
      STALL,
      CATCHUP
   } state_t;

   state_t            state, state_n;
   logic              edge_d;
   logic [ACNT_W-1:0] acnt_q, acnt_n;
   logic [SCNT_W-1:0] scnt_q, scnt_n;
   logic [TCKC_W-1:0] tckc_q, tckc_n;
   logic [SCNT_W-1:0] scnt_top_q, scnt_top_n;
   logic [TCKC_W-1:0] tckc_top_q, tckc_top_n;
   logic              tick_q, tick_n;
   logic              early_q, early_n;
   logic              load;
   logic [ACNT_W-1:0] next_angle;
`ifdef HWAG_ACNT_CATCHUP_EN
   logic [ACNT_W-1:0] target_q, target_n;
   logic              overrun_q, overrun_n;
`endif

   // >= so that a tooth angle loaded beyond the top still wraps on its first tick
   assign next_angle = (acnt_q >= bus.acnt_top) ? '0 : acnt_q + ACNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         edge_d     <= 1'b0;
         acnt_q     <= '0;
         scnt_q     <= '0;
         tckc_q     <= '0;
         scnt_top_q <= '0;
         tckc_top_q <= '0;
         tick_q     <= 1'b0;
         early_q    <= 1'b0;
`ifdef HWAG_ACNT_CATCHUP_EN
         target_q   <= '0;
         overrun_q  <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         edge_d     <= bus.tooth_edge;
         acnt_q     <= acnt_n;
         scnt_q     <= scnt_n;
         tckc_q     <= tckc_n;
         scnt_top_q <= scnt_top_n;
         tckc_top_q <= tckc_top_n;
         tick_q     <= tick_n;
         early_q    <= early_n;
`ifdef HWAG_ACNT_CATCHUP_EN
         target_q   <= target_n;
         overrun_q  <= overrun_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      acnt_n     = acnt_q;
      scnt_n     = scnt_q;
      tckc_n     = tckc_q;
      scnt_top_n = scnt_top_q;
      tckc_top_n = tckc_top_q;
      tick_n     = 1'b0;
      early_n    = 1'b0;
      load       = 1'b0;
`ifdef HWAG_ACNT_CATCHUP_EN
      target_n   = target_q;
      overrun_n  = 1'b0;
`endif
      if (!bus.ena) begin
         state_n = IDLE;
         acnt_n  = '0;
         scnt_n  = '0;
         tckc_n  = '0;
      end else begin
         case (state)
            IDLE: begin
               acnt_n  = '0;
               scnt_n  = '0;
               tckc_n  = '0;
               state_n = SYNC;
            end
            SYNC: begin
               if (edge_d) load = 1'b1;
            end
            RUN: begin
               // An edge always beats a tick landing in the same clock
               if (edge_d) begin
                  if (tckc_q < tckc_top_q) early_n = 1'b1;
`ifdef HWAG_ACNT_CATCHUP_EN
                  if (tckc_q < tckc_top_q) begin
                     target_n   = bus.tooth_angle;
                     scnt_top_n = bus.scnt_top;
                     tckc_top_n = bus.tckc_top;
                     scnt_n     = '0;
                     tckc_n     = '0;
                     state_n    = CATCHUP;
                  end else begin
                     load = 1'b1;
                  end
`else
                  load = 1'b1;
`endif
               end else if (tckc_q >= tckc_top_q) begin
                  state_n = STALL;
               end else if (scnt_q == scnt_top_q) begin
                  scnt_n = '0;
                  acnt_n = next_angle;
                  tckc_n = tckc_q + TCKC_W'(1);
                  tick_n = 1'b1;
                  if ((tckc_q + TCKC_W'(1)) == tckc_top_q) state_n = STALL;
               end else begin
                  scnt_n = scnt_q + SCNT_W'(1);
               end
            end
            STALL: begin
               if (edge_d) load = 1'b1;
            end
`ifdef HWAG_ACNT_CATCHUP_EN
            CATCHUP: begin
               if (edge_d) begin
                  overrun_n = 1'b1;
                  load      = 1'b1;
               end else if (acnt_q == target_q) begin
                  state_n = RUN;
               end else begin
                  acnt_n = next_angle;
                  tick_n = 1'b1;
               end
            end
`endif
            default: state_n = IDLE;
         endcase

         if (load) begin
            acnt_n     = bus.tooth_angle;
            scnt_n     = '0;
            tckc_n     = '0;
            scnt_top_n = bus.scnt_top;
            tckc_top_n = bus.tckc_top;
            state_n    = RUN;
         end
      end
   end

   assign bus.acnt       = acnt_q;
   assign bus.acnt_tick  = tick_q;
   assign bus.acnt_valid = (state == RUN) || (state == STALL) || (state == CATCHUP);
   assign bus.stall      = (state == STALL);
   assign bus.early_if   = early_q;
`ifdef HWAG_ACNT_CATCHUP_EN
   assign bus.overrun_if = overrun_q;
`else
   assign bus.overrun_if = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_angle_counter.sv
// Directed bench for hwag_angle_counter; covers both builds of HWAG_ACNT_CATCHUP_EN.
module tb_hwag_angle_counter;

   localparam int ACNT_W = 24;
   localparam int SCNT_W = 22;
   localparam int TCKC_W = 19;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   hwag_angle_if #(.ACNT_W(ACNT_W), .SCNT_W(SCNT_W), .TCKC_W(TCKC_W)) bus ();

   hwag_angle_counter #(.ACNT_W(ACNT_W), .SCNT_W(SCNT_W), .TCKC_W(TCKC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic stepClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input int acnt, input int tick, input int valid, input int stall);
      checkOutput({tag, "_acnt"},  32'(bus.acnt),       32'(acnt));
      checkOutput({tag, "_tick"},  32'(bus.acnt_tick),  32'(tick));
      checkOutput({tag, "_valid"}, 32'(bus.acnt_valid), 32'(valid));
      checkOutput({tag, "_stall"}, 32'(bus.stall),      32'(stall));
   endtask

   // One-clock tooth edge; tooth data held afterwards so it is valid when edge_d is acted on
   task automatic applyStimulus(input int angle, input int stop, input int ttop);
      @(negedge clk);
      bus.tooth_edge  = 1'b1;
      bus.tooth_angle = ACNT_W'(angle);
      bus.scnt_top    = SCNT_W'(stop);
      bus.tckc_top    = TCKC_W'(ttop);
      @(negedge clk);
      bus.tooth_edge  = 1'b0;
   endtask

   initial begin
      int t4 [4];
      t4 = '{359, 0, 1, 2};
      rst             = 1'b1;
      bus.ena         = 1'b0;
      bus.tooth_edge  = 1'b0;
      bus.tooth_angle = '0;
      bus.scnt_top    = '0;
      bus.tckc_top    = '0;
      bus.acnt_top    = ACNT_W'(359);
      stepClk(3);
      checkState("reset", 0, 0, 0, 0);
      checkOutput("reset_early", 32'(bus.early_if), 0);
      checkOutput("reset_overrun", 32'(bus.overrun_if), 0);
      rst = 1'b0;
      bus.ena = 1'b1;
      stepClk(1);

      $display("[TB] test 1: sync and count to budget");
      applyStimulus(12, 3, 6);
      stepClk(1);
      checkState("t1_load", 12, 0, 1, 0);
      for (int k = 1; k <= 6; k++) begin
         stepClk(3);
         checkOutput("t1_hold", 32'(bus.acnt), 32'(12 + k - 1));
         stepClk(1);
         checkState("t1_tick", 12 + k, 1, 1, (k == 6) ? 1 : 0);
      end
      stepClk(5);
      checkState("t1_stall", 18, 0, 1, 1);
      stepClk(10);

      $display("[TB] test 2: edge releases stall");
      applyStimulus(18, 3, 6);
      stepClk(1);
      checkState("t2_resync", 18, 0, 1, 0);
      checkOutput("t2_no_early", 32'(bus.early_if), 0);
      stepClk(3);
      checkOutput("t2_hold", 32'(bus.acnt), 18);
      stepClk(1);
      checkState("t2_tick", 19, 1, 1, 0);

      $display("[TB] test 5: abort mid-run and resync");
      bus.ena = 1'b0;
      stepClk(1);
      checkState("t5_abort", 0, 0, 0, 0);
      checkOutput("t5_abort_early", 32'(bus.early_if), 0);
      bus.ena = 1'b1;
      stepClk(1);
      checkState("t5_sync_wait", 0, 0, 0, 0);
      applyStimulus(12, 3, 6);
      stepClk(1);
      checkState("t5_resync", 12, 0, 1, 0);
      checkOutput("t5_no_early", 32'(bus.early_if), 0);
      for (int k = 1; k <= 3; k++) begin
         stepClk(4);
         checkOutput("t5_count", 32'(bus.acnt), 32'(12 + k));
      end

      $display("[TB] test 3: early edge");
      applyStimulus(18, 3, 6);
      stepClk(1);
`ifdef HWAG_ACNT_CATCHUP_EN
      checkState("t3_early", 15, 0, 1, 0);
      checkOutput("t3_early_if", 32'(bus.early_if), 1);
      for (int v = 16; v <= 18; v++) begin
         stepClk(1);
         checkState("t3_catchup", v, 1, 1, 0);
         checkOutput("t3_early_clr", 32'(bus.early_if), 0);
      end
      stepClk(1);
      checkState("t3_done", 18, 0, 1, 0);

      $display("[TB] test 6: edge during catchup");
      applyStimulus(25, 3, 6);
      stepClk(1);
      checkState("t6_early", 18, 0, 1, 0);
      checkOutput("t6_early_if", 32'(bus.early_if), 1);
      applyStimulus(30, 3, 6);
      stepClk(1);
      checkState("t6_overrun", 30, 0, 1, 0);
      checkOutput("t6_overrun_if", 32'(bus.overrun_if), 1);
      stepClk(3);
      checkOutput("t6_hold", 32'(bus.acnt), 30);
      checkOutput("t6_overrun_clr", 32'(bus.overrun_if), 0);
      stepClk(1);
      checkState("t6_tick", 31, 1, 1, 0);
`else
      checkState("t3_jump", 18, 0, 1, 0);
      checkOutput("t3_early_if", 32'(bus.early_if), 1);
      checkOutput("t3_overrun_if", 32'(bus.overrun_if), 0);
      stepClk(1);
      checkOutput("t3_early_clr", 32'(bus.early_if), 0);
      stepClk(2);
      checkOutput("t3_hold", 32'(bus.acnt), 18);
      stepClk(1);
      checkState("t3_tick", 19, 1, 1, 0);
      applyStimulus(25, 3, 6);
      stepClk(1);
      checkState("t6_jump", 25, 0, 1, 0);
      checkOutput("t6_overrun_if", 32'(bus.overrun_if), 0);
`endif

      $display("[TB] test 4: wrap at acnt_top with one tick per clock");
      bus.ena = 1'b0;
      stepClk(1);
      bus.ena = 1'b1;
      stepClk(1);
      applyStimulus(358, 0, 4);
      stepClk(1);
      checkState("t4_load", 358, 0, 1, 0);
      for (int k = 0; k < 4; k++) begin
         stepClk(1);
         checkState("t4_tick", t4[k], 1, 1, (k == 3) ? 1 : 0);
      end
      stepClk(1);
      checkState("t4_stall", 2, 0, 1, 1);

      $display("[TB] zero tick budget and angle beyond top");
      applyStimulus(100, 0, 0);
      stepClk(1);
      checkState("zb_load", 100, 0, 1, 0);
      stepClk(1);
      checkState("zb_stall", 100, 0, 1, 1);
      applyStimulus(400, 0, 2);
      stepClk(1);
      checkState("ot_load", 400, 0, 1, 0);
      stepClk(1);
      checkState("ot_wrap", 0, 1, 1, 0);
      stepClk(1);
      checkState("ot_stall", 1, 1, 1, 1);

      rst = 1'b1;
      stepClk(1);
      checkState("rst_mid", 0, 0, 0, 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
